// File: rtl/uart_beacon_gen.sv
// uart_beacon_gen: periodic beacon that snapshots a free-running tick counter
// and streams it to a UART transmitter over a valid/ready byte interface,
// either as raw binary (MSB byte first) or as uppercase ASCII hex with an
// optional CR/LF terminator. Ticks that land while a frame is still being
// sent are dropped and counted in a saturating overrun counter.
module uart_beacon_gen #(
  parameter int CNT_W  = 16,
  parameter int PERIOD = 10000,
  parameter int TERM   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ascii_mode,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic [CNT_W-1:0] count,
  output logic [7:0]       overrun_cnt,
  output logic             busy
);

  localparam int TIMER_W = $clog2(PERIOD);
  localparam int NUM_BIN = CNT_W / 8;
  localparam int NUM_ASC = CNT_W / 4;
  localparam int IDX_W   = $clog2(NUM_ASC + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0]   BIN_LAST   = IDX_W'(NUM_BIN - 1);
  localparam logic [IDX_W-1:0]   ASC_LAST   = IDX_W'(NUM_ASC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CR,
    LF
  } state_t;

  state_t state;
  state_t state_next;

  logic [TIMER_W-1:0] timer;
  logic               tick;
  logic [CNT_W-1:0]   frame;
  logic               frame_ascii;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               last_data;
  logic [3:0]         nibble;
  logic [7:0]         hex_char;

  assign tick      = en && (timer == TIMER_LAST);
  assign accept    = tx_valid && tx_ready;
  assign last_data = (idx == (frame_ascii ? ASC_LAST : BIN_LAST));

  // The frame register is shifted left as bytes go out, so the byte or
  // nibble currently on offer always sits at the top of the register.
  assign nibble   = frame[CNT_W-1 -: 4];
  assign hex_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                     : (8'h37 + {4'h0, nibble});

  // Tick timer: runs 0..PERIOD-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (!en || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Tick number and overrun accounting; a tick outside IDLE is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      overrun_cnt <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
      if (state != IDLE && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  // Frame capture on an accepted tick, then shift out one unit per acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame       <= '0;
      frame_ascii <= 1'b0;
      idx         <= '0;
    end else if (state == IDLE && tick) begin
      frame       <= count;
      frame_ascii <= ascii_mode;
      idx         <= '0;
    end else if (state == SEND && accept) begin
      frame <= frame_ascii ? (frame << 4) : (frame << 8);
      idx   <= idx + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and byte-interface outputs; valid depends only on state.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_next = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = frame_ascii ? hex_char : frame[CNT_W-1 -: 8];
        if (accept && last_data) begin
          state_next = (frame_ascii && TERM != 0) ? CR : IDLE;
        end
      end
      CR: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = 8'h0D;
        if (accept) begin
          state_next = LF;
        end
      end
      LF: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = 8'h0A;
        if (accept) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_beacon_gen.md
# uart_beacon_gen

Periodic UART message generator: every PERIOD enabled clocks it snapshots a free-running CNT_W-bit tick counter and streams it as a byte frame to a UART transmitter over a valid/ready byte interface. The frame is either raw binary (MSB byte first) or uppercase ASCII hex with an optional CR/LF terminator. It sits between the top level and the UART TX, replacing the fixed 8-bit delay/counter/send logic. It adds backpressure handling, wider counters, an ASCII mode and overrun accounting.

## Interface
- CNT_W, 16, tick counter width; multiple of 8, range 8..64
- PERIOD, 10000, clocks between ticks; minimum 2
- TERM, 1, 1 = append 0x0D,0x0A to ASCII frames; 0 = no terminator

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  tick timer enable
- ascii_mode  in  1  0 = binary frame, 1 = ASCII hex frame; sampled at frame start
- tx_ready  in  1  UART accepts tx_data this cycle
- tx_valid  out  1  tx_data valid
- tx_data  out  8  frame byte
- count  out  CNT_W  next value to be sent (tick number)
- overrun_cnt  out  8  ticks dropped because a frame was in progress; saturating
- busy  out  1  frame in progress

## Operation
- Timer:
  - Counts 0..PERIOD-1 while en=1 and wraps to 0.
  - When en=0 the timer is held at 0.
  - A tick occurs in the cycle where en=1 and timer==PERIOD-1.
- On every tick, count increments modulo 2^CNT_W.
- Tick while IDLE:
  - Latch the current count into the frame register.
  - Latch ascii_mode.
  - Enter SEND.
- Tick while not IDLE:
  - The tick value is skipped and not sent.
  - overrun_cnt increments, saturating at 255.
- Binary frame: CNT_W/8 bytes, MSB byte first.
- ASCII frame:
  - CNT_W/4 characters, MSB nibble first.
  - Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
  - If TERM=1, 0x0D then 0x0A follow.
- State machine:
  - IDLE -> SEND on tick.
  - SEND -> SEND while bytes remain; the byte index advances on each acceptance.
  - SEND -> CR after the last data byte is accepted, if ASCII and TERM=1.
  - SEND -> IDLE after the last data byte is accepted, otherwise.
  - CR -> LF on acceptance.
  - LF -> IDLE on acceptance.
- busy=1 in every state except IDLE.
- Handshake:
  - A byte transfers on a rising edge where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - tx_valid does not depend combinationally on tx_ready.
  - tx_valid remains high between bytes of a frame when the next byte is available.
- en deasserted mid-frame: the current frame completes; only new ticks stop.
- Reset: asynchronous and effective immediately, including mid-frame.
  - tx_valid=0, tx_data=0x00, count=0, overrun_cnt=0, busy=0.
  - State IDLE, timer 0.
  - The partial frame is abandoned.

## Timing
- First tick: PERIOD cycles after the first cycle with en=1 (the timer reads 0 in that first cycle).
- Latency: tx_valid and busy rise on the clock edge ending the tick cycle; the first byte is offered the next cycle.
- With tx_ready held at 1, one byte transfers per cycle.
  - Binary frame length: CNT_W/8 cycles.
  - ASCII frame length: CNT_W/4 + 2·TERM cycles.
- tx_valid and busy fall on the edge that accepts the last byte.
  - A tick in that same cycle counts as an overrun, because the state is not yet IDLE.
- count and overrun_cnt update on the edge ending the tick cycle.
- Maximum sustained frame rate without overrun: PERIOD ≥ frame length + 1.

## Test plan
- Binary, no backpressure:
  - Stimulus: CNT_W=16, PERIOD=20, en=1 from cycle 0, tx_ready=1.
  - Response: bytes 0x00,0x00 in cycles 20-21; 0x00,0x01 in cycles 40-41; count=2 after cycle 40.
- ASCII with terminator:
  - Stimulus: CNT_W=16, TERM=1, ascii_mode=1, count preloaded via ticks to 0x1A3F.
  - Response: 0x31,0x41,0x33,0x46,0x0D,0x0A.
- Backpressure:
  - Stimulus: tx_ready low for 7 cycles during byte 2.
  - Response: tx_valid=1 and tx_data constant for all 7 cycles; the byte transfers once when tx_ready rises; no byte is duplicated or lost.
- Overrun:
  - Stimulus: PERIOD=4, ASCII 6-byte frame, tx_ready=1.
  - Response: every second tick is dropped; overrun_cnt increments each time; sent values are 0,2,4,...
  - Extended run: overrun_cnt saturates at 255.
- Wrap:
  - Stimulus: CNT_W=8, binary.
  - Response: value 0xFF is sent, then 0x00; count wraps to 0.
- Reset and enable mid-frame:
  - Stimulus: assert rst_n=0 during byte 3 of an ASCII frame.
  - Response: tx_valid, busy and count are 0 with no clock edge; after release, the first frame sends 0 again.
  - Stimulus: drop en mid-frame.
  - Response: the frame finishes and no further ticks occur.
